// File: rtl/fifo_destino_pkg.sv
// Shared defaults and helpers for the destination FIFO and its register file.
package fifo_destino_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_AF_THRESH  = 6;
  localparam int DEF_AE_THRESH  = 2;

  // What the FIFO does to its occupancy on a given edge.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_t;

  // Classify the accepted write/read pair into an occupancy operation.
  function automatic fifo_op_t classify_op(input logic wr_acc, input logic rd_acc);
    return fifo_op_t'({wr_acc, rd_acc});
  endfunction

endpackage

// File: rtl/fifo_destino_memoria_dual.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port and one
// synchronous read port whose output register clears on reset and holds
// its value when no read is issued.
module memoria_dual #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  // Storage array: no reset so it maps onto RAM resources.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; output holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/fifo_destino.sv
// Destination FIFO behind the routing arbiter: buffers words, raises pause
// for back-pressure, exposes status flags and a one-cycle-latency pop port,
// and latches a sticky error on overflow or underflow.
module fifo_destino
  import fifo_destino_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  pause,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  valid_reg;
  logic                  error_reg;

  logic     wr_acc;
  logic     rd_acc;
  logic     fault;
  fifo_op_t op;

  // Flags are pure decodes of the registered occupancy.
  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign almost_empty = (count_reg <= CW'(AE_THRESH));
  assign pause        = (count_reg >= CW'(AF_THRESH));

  // Acceptance uses pre-edge flags: a full FIFO rejects a write even if a
  // read frees a slot this same edge, and an empty FIFO never bypasses.
  assign wr_acc = push && !full;
  assign rd_acc = pop && !empty;
  assign fault  = (push && full) || (pop && empty);
  assign op     = classify_op(wr_acc, rd_acc);

  // Pointer, occupancy, read-valid and sticky error state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
      end
      case (op)
        OP_WRITE: count_reg <= count_reg + CW'(1);
        OP_READ:  count_reg <= count_reg - CW'(1);
        default:  count_reg <= count_reg;
      endcase
      valid_reg <= rd_acc;
      if (fault) begin
        error_reg <= 1'b1;
      end
    end
  end

  assign valid_out = valid_reg;
  assign error     = error_reg;

  memoria_dual #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr_reg),
    .wr_data(data_in),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr_reg),
    .rd_data(data_out)
  );

endmodule

// File: tb/tb_fifo_destino.sv
// Bench for fifo_destino: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the FIFO rules.
module tb_fifo_destino;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] data_in;
  logic       push;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       pause;
  logic       full;
  logic       empty;
  logic       almost_empty;
  logic       error;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [5:0] q[$];
  logic [5:0] m_dout;
  logic       m_valid;
  logic       m_error;
  logic       pause_d;

  always #5 clk = ~clk;

  fifo_destino dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .push        (push),
    .pop         (pop),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .pause       (pause),
    .full        (full),
    .empty       (empty),
    .almost_empty(almost_empty),
    .error       (error)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".data_out"},     {2'b00, data_out}, {2'b00, m_dout});
    check({tag, ".valid_out"},    {7'd0, valid_out}, {7'd0, m_valid});
    check({tag, ".pause"},        {7'd0, pause},     {7'd0, 1'(n >= AF)});
    check({tag, ".full"},         {7'd0, full},      {7'd0, 1'(n == DEPTH)});
    check({tag, ".empty"},        {7'd0, empty},     {7'd0, 1'(n == 0)});
    check({tag, ".almost_empty"}, {7'd0, almost_empty}, {7'd0, 1'(n <= AE)});
    check({tag, ".error"},        {7'd0, error},     {7'd0, m_error});
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_error = 1'b0;
  endtask

  // One clock of traffic; model applies the FIFO rules with pre-edge occupancy.
  task automatic step(input string tag, input logic p, input logic r, input logic [5:0] d);
    bit was_full, was_empty;
    @(negedge clk);
    push = p; pop = r; data_in = d;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (r && !was_empty) begin
      m_dout  = q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (p && !was_full) q.push_back(d);
    if ((p && was_full) || (r && was_empty)) m_error = 1'b1;
    #1;
    $display("step %-8s push=%0b pop=%0b din=%02h -> dout=%02h v=%0b cnt=%0d pause=%0b full=%0b empty=%0b ae=%0b err=%0b",
             tag, p, r, d, data_out, valid_out, q.size(), pause, full, empty, almost_empty, error);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; reset = 1'b1;
    #1;
    model_reset();
    $display("reset %s asserted", tag);
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    model_reset();
    #1;
    check_all("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Fill to full, then overflow
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 6'(i));
    step("ovf", 1'b1, 1'b0, 6'h3F);

    // Drain in order, then underflow
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 6'h00);
    step("udf", 1'b0, 1'b1, 6'h00);

    // Reset while holding five words
    do_reset("pre5");
    for (int i = 0; i < 5; i++) step("load5", 1'b1, 1'b0, 6'(6'h20 + i));
    do_reset("mid");

    // Pointer wrap
    for (int i = 0; i < 5; i++) step("wpush", 1'b1, 1'b0, 6'(6'h30 + i));
    for (int i = 0; i < 5; i++) step("wpop", 1'b0, 1'b1, 6'h00);
    for (int i = 0; i < 6; i++) step("wpush2", 1'b1, 1'b0, 6'(6'h10 + i));
    for (int i = 0; i < 6; i++) step("wpop2", 1'b0, 1'b1, 6'h00);

    // Simultaneous push/pop at mid, full and empty occupancy
    for (int i = 0; i < 4; i++) step("s4", 1'b1, 1'b0, 6'(6'h04 + i));
    step("both4", 1'b1, 1'b1, 6'h2A);
    for (int i = 0; i < 4; i++) step("s8", 1'b1, 1'b0, 6'(6'h08 + i));
    step("both8", 1'b1, 1'b1, 6'h15);
    for (int i = 0; i < 7; i++) step("s0", 1'b0, 1'b1, 6'h00);
    step("both0", 1'b1, 1'b1, 6'h1B);

    // Arbiter-like producer reacting to pause with one cycle of latency
    do_reset("arb");
    pause_d = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step("arb", !pause_d, 1'b0, 6'($urandom_range(0, 63)));
      pause_d = pause;
    end

    // Randomized traffic with varying push/pop bias
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i / 100) % 2 == 0 ? 70 : 30;
      step("rnd", 1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) < 100 - bias),
           6'($urandom_range(0, 63)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound in case the run stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
